cdb_arbiter: RTL and testbench

Completion-bus arbiter between the execution units (ALU, LSU, MUL) and the common data bus (CDB) that feeds the reorder buffer and the reservation stations. Each unit pushes finished results (ROB index, physical destination, value) through a valid/ready handshake into a small per-source queue. A round-robin scheduler drains one result per cycle onto a registered CDB output. The arbiter honours a downstream stall and a pipeline flush.

---
 rtl/ooo_pkg.sv | 31 +++
 rtl/cdb_arbiter_if.sv | 52 +++++
 rtl/cdb_arbiter_src_q.sv | 73 +++++++
 rtl/cdb_arbiter.sv | 115 +++++++++++
 tb/tb_cdb_arbiter.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/ooo_pkg.sv
// ooo_pkg: shared definitions for the out-of-order completion path.
//   - source encodings of the execution units that feed the CDB
//   - field widths of a completed result
//   - packed result record carried from an execution unit to the CDB
//   - rr_add: modulo-NUM_SRC increment used by the round-robin scheduler
package ooo_pkg;

   localparam int SRC_ALU   = 0;
   localparam int SRC_LSU   = 1;
   localparam int SRC_MUL   = 2;
   localparam int NUM_SRC   = 3;
   localparam int SRC_W     = 2;

   localparam int ROB_IDX_W = 5;
   localparam int PRD_W     = 5;
   localparam int XLEN      = 32;

   typedef struct packed {
      logic [ROB_IDX_W-1:0] rob_idx;
      logic [PRD_W-1:0]     prd;
      logic [XLEN-1:0]      value;
   } cdb_result_t;

   // (p + k) mod NUM_SRC, for p in 0..NUM_SRC-1.
   function automatic logic [SRC_W-1:0] rr_add(logic [SRC_W-1:0] p, int unsigned k);
      int unsigned s;
      s = int'(p) + k;
      return SRC_W'(s % NUM_SRC);
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: handshake and bus signals of the completion-bus arbiter.
//   Per source (alu/lsu/mul): valid_i, ready_o, rob_idx_i, prd_i, value_i.
//   Control: flush_i, cdb_stall_i. CDB: cdb_valid_o, cdb_src_o, cdb_rob_idx_o,
//   cdb_prd_o, cdb_value_o. Debug: dbg_rr_ptr_o (round-robin pointer).
//
// Handshake: a source result transfers on a rising edge where valid_i and
// ready_o are both high and flush_i is low; ready_o never depends on valid_i.
// A CDB result is consumed on an edge where cdb_valid_o is high and
// cdb_stall_i is low; while stalled the CDB outputs hold bit-stable.
// master = the environment (execution units + CDB consumer), slave = arbiter.
interface cdb_arbiter_if;
   import ooo_pkg::*;

   logic                 flush_i;
   logic                 cdb_stall_i;

   logic                 alu_valid_i, lsu_valid_i, mul_valid_i;
   logic                 alu_ready_o, lsu_ready_o, mul_ready_o;
   logic [ROB_IDX_W-1:0] alu_rob_idx_i, lsu_rob_idx_i, mul_rob_idx_i;
   logic [PRD_W-1:0]     alu_prd_i, lsu_prd_i, mul_prd_i;
   logic [XLEN-1:0]      alu_value_i, lsu_value_i, mul_value_i;

   logic                 cdb_valid_o;
   logic [SRC_W-1:0]     cdb_src_o;
   logic [ROB_IDX_W-1:0] cdb_rob_idx_o;
   logic [PRD_W-1:0]     cdb_prd_o;
   logic [XLEN-1:0]      cdb_value_o;
   logic [SRC_W-1:0]     dbg_rr_ptr_o;

   modport master (
      output flush_i, cdb_stall_i,
      output alu_valid_i, lsu_valid_i, mul_valid_i,
      output alu_rob_idx_i, lsu_rob_idx_i, mul_rob_idx_i,
      output alu_prd_i, lsu_prd_i, mul_prd_i,
      output alu_value_i, lsu_value_i, mul_value_i,
      input  alu_ready_o, lsu_ready_o, mul_ready_o,
      input  cdb_valid_o, cdb_src_o, cdb_rob_idx_o, cdb_prd_o, cdb_value_o,
      input  dbg_rr_ptr_o
   );

   modport slave (
      input  flush_i, cdb_stall_i,
      input  alu_valid_i, lsu_valid_i, mul_valid_i,
      input  alu_rob_idx_i, lsu_rob_idx_i, mul_rob_idx_i,
      input  alu_prd_i, lsu_prd_i, mul_prd_i,
      input  alu_value_i, lsu_value_i, mul_value_i,
      output alu_ready_o, lsu_ready_o, mul_ready_o,
      output cdb_valid_o, cdb_src_o, cdb_rob_idx_o, cdb_prd_o, cdb_value_o,
      output dbg_rr_ptr_o
   );

endinterface

// File: rtl/cdb_arbiter_src_q.sv
// cdb_src_q: Q_DEPTH-deep FIFO of completed results for one execution unit.
//   clk_i, reset_i : clock, synchronous active-high reset
//   flush_i        : empty the queue; overrides push and pop
//   push_i, data_i : offered result (accepted only while ready_o)
//   pop_i          : remove the head (ignored when empty)
//   ready_o        : count < Q_DEPTH, from registered state only
//   empty_o        : count == 0
//   head_o         : oldest stored result
module cdb_src_q
   import ooo_pkg::*;
#(
   parameter int Q_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        flush_i,
   input  logic        push_i,
   input  cdb_result_t data_i,
   input  logic        pop_i,
   output logic        ready_o,
   output logic        empty_o,
   output cdb_result_t head_o
);

   localparam int PTR_W = $clog2(Q_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   cdb_result_t      mem_q [Q_DEPTH];
   logic             push_ok, pop_ok;

   assign ready_o = (count_q < CNT_W'(Q_DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   assign push_ok = push_i & ready_o & ~flush_i;
   assign pop_ok  = pop_i & ~empty_o & ~flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Depth is a power of two, so pointer wrap is the natural overflow.
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: only slots covered by count are ever read.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: drains three per-unit result queues onto a registered CDB
// with a round-robin scheduler, honouring a downstream stall and a flush.
//   clk_i, reset_i : clock, synchronous active-high reset
//   bus            : cdb_arbiter_if.slave (source handshakes, flush, stall,
//                    CDB outputs, round-robin pointer for debug)
module cdb_arbiter
   import ooo_pkg::*;
#(
   parameter int Q_DEPTH = 2
) (
   input  logic          clk_i,
   input  logic          reset_i,
   cdb_arbiter_if.slave  bus
);

   logic [NUM_SRC-1:0] q_push, q_pop, q_ready, q_empty;
   cdb_result_t        q_data [NUM_SRC];
   cdb_result_t        q_head [NUM_SRC];

   assign q_push[SRC_ALU] = bus.alu_valid_i;
   assign q_push[SRC_LSU] = bus.lsu_valid_i;
   assign q_push[SRC_MUL] = bus.mul_valid_i;
   assign q_data[SRC_ALU] = {bus.alu_rob_idx_i, bus.alu_prd_i, bus.alu_value_i};
   assign q_data[SRC_LSU] = {bus.lsu_rob_idx_i, bus.lsu_prd_i, bus.lsu_value_i};
   assign q_data[SRC_MUL] = {bus.mul_rob_idx_i, bus.mul_prd_i, bus.mul_value_i};
   assign bus.alu_ready_o = q_ready[SRC_ALU];
   assign bus.lsu_ready_o = q_ready[SRC_LSU];
   assign bus.mul_ready_o = q_ready[SRC_MUL];

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_q
      cdb_src_q #(.Q_DEPTH(Q_DEPTH)) u_q (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .flush_i (bus.flush_i),
         .push_i  (q_push[s]),
         .data_i  (q_data[s]),
         .pop_i   (q_pop[s]),
         .ready_o (q_ready[s]),
         .empty_o (q_empty[s]),
         .head_o  (q_head[s])
      );
   end

   // Output register and scheduler state.
   logic             cdb_valid_q, cdb_valid_d;
   logic [SRC_W-1:0] cdb_src_q, cdb_src_d;
   cdb_result_t      cdb_res_q, cdb_res_d;
   logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

   logic             out_free;
   logic             gnt_found;
   logic [SRC_W-1:0] gnt_idx;
   logic [SRC_W-1:0] cand;

   assign out_free = ~cdb_valid_q | ~bus.cdb_stall_i;

   // First non-empty queue scanning from rr_ptr upward (mod NUM_SRC).
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = rr_ptr_q;
      cand      = rr_ptr_q;
      for (int k = 0; k < NUM_SRC; k++) begin
         cand = rr_add(rr_ptr_q, k);
         if (!gnt_found && !q_empty[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign q_pop = (out_free && gnt_found && !bus.flush_i)
                  ? (NUM_SRC'(1) << gnt_idx) : '0;

   always_comb begin
      cdb_valid_d = cdb_valid_q;
      cdb_src_d   = cdb_src_q;
      cdb_res_d   = cdb_res_q;
      rr_ptr_d    = rr_ptr_q;
      if (bus.flush_i) begin
         // rr_ptr survives a flush; only the valid bit is dropped.
         cdb_valid_d = 1'b0;
      end else if (out_free) begin
         if (gnt_found) begin
            cdb_valid_d = 1'b1;
            cdb_src_d   = gnt_idx;
            cdb_res_d   = q_head[gnt_idx];
            rr_ptr_d    = rr_add(gnt_idx, 1);
         end else begin
            cdb_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cdb_valid_q <= 1'b0;
         cdb_src_q   <= '0;
         cdb_res_q   <= '0;
         rr_ptr_q    <= '0;
      end else begin
         cdb_valid_q <= cdb_valid_d;
         cdb_src_q   <= cdb_src_d;
         cdb_res_q   <= cdb_res_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign bus.cdb_valid_o   = cdb_valid_q;
   assign bus.cdb_src_o     = cdb_src_q;
   assign bus.cdb_rob_idx_o = cdb_res_q.rob_idx;
   assign bus.cdb_prd_o     = cdb_res_q.prd;
   assign bus.cdb_value_o   = cdb_res_q.value;
   assign bus.dbg_rr_ptr_o  = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table-driven check of cdb_arbiter (Q_DEPTH=2) plus
// hand-written reset and single-push sequences.
module tb_cdb_arbiter;
   import ooo_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cdb_arbiter_if bus ();

   cdb_arbiter #(.Q_DEPTH(2)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // One row = inputs held for one clock edge and the outputs expected #1 later.
   // push / erdy bit order: [0]=ALU, [1]=LSU, [2]=MUL.
   typedef struct {
      logic       rst, flush, stall;
      logic [2:0] push;
      logic [4:0] ra, rl, rm;
      logic       ev;
      logic [1:0] esrc;
      logic [4:0] erob;
      logic [2:0] erdy;
      logic [1:0] err;
      logic       ezero;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(logic r, logic f, logic s, logic [2:0] p,
                               logic [4:0] ra, logic [4:0] rl, logic [4:0] rm,
                               logic ev, logic [1:0] es, logic [4:0] er,
                               logic [2:0] rdy, logic [1:0] rr, logic ez);
      vec_t v;
      v.rst = r; v.flush = f; v.stall = s; v.push = p;
      v.ra = ra; v.rl = rl; v.rm = rm;
      v.ev = ev; v.esrc = es; v.erob = er; v.erdy = rdy; v.err = rr; v.ezero = ez;
      return v;
   endfunction

   // Payload derived from source and ROB index so each result is unique.
   function automatic logic [4:0] prd_of(logic [4:0] rob);
      return rob + 5'd3;
   endfunction

   function automatic logic [31:0] val_of(logic [1:0] src, logic [4:0] rob);
      return 32'hC0DE_0000 | ({30'd0, src} << 8) | {27'd0, rob};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(logic r, logic f, logic s, logic [2:0] p,
                        logic [4:0] ra, logic [4:0] rl, logic [4:0] rm);
      rst               = r;
      bus.flush_i       = f;
      bus.cdb_stall_i   = s;
      bus.alu_valid_i   = p[0];
      bus.lsu_valid_i   = p[1];
      bus.mul_valid_i   = p[2];
      bus.alu_rob_idx_i = ra; bus.alu_prd_i = prd_of(ra); bus.alu_value_i = val_of(2'd0, ra);
      bus.lsu_rob_idx_i = rl; bus.lsu_prd_i = prd_of(rl); bus.lsu_value_i = val_of(2'd1, rl);
      bus.mul_rob_idx_i = rm; bus.mul_prd_i = prd_of(rm); bus.mul_value_i = val_of(2'd2, rm);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(string tag);
      chk({tag, " valid"}, {31'd0, bus.cdb_valid_o}, 32'd0);
      chk({tag, " src"},   {30'd0, bus.cdb_src_o}, 32'd0);
      chk({tag, " rob"},   {27'd0, bus.cdb_rob_idx_o}, 32'd0);
      chk({tag, " prd"},   {27'd0, bus.cdb_prd_o}, 32'd0);
      chk({tag, " value"}, bus.cdb_value_o, 32'd0);
   endtask

   task automatic chk_ready(string tag, logic [2:0] exp);
      chk({tag, " ready"}, {29'd0, bus.mul_ready_o, bus.lsu_ready_o, bus.alu_ready_o},
          {29'd0, exp});
   endtask

   initial begin
      vec_t v;
      string tag;

      drive(1'b1, 1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);

      // Reset: two cycles asserted, then five idle cycles.
      step();
      step();
      chk_zero("rst");
      drive(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         tag = $sformatf("idle%0d", i);
         chk_zero(tag);
         chk_ready(tag, 3'b111);
         chk({tag, " rr"}, {30'd0, bus.dbg_rr_ptr_o}, 32'd0);
      end

      // Single ALU push with explicit payload: visible one edge after acceptance.
      drive(1'b0, 1'b0, 1'b0, 3'b001, 5'd3, 5'd0, 5'd0);
      bus.alu_prd_i   = 5'd17;
      bus.alu_value_i = 32'hDEAD_BEEF;
      step();
      chk("single t0 valid", {31'd0, bus.cdb_valid_o}, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
      step();
      chk("single valid", {31'd0, bus.cdb_valid_o}, 32'd1);
      chk("single src",   {30'd0, bus.cdb_src_o}, 32'd0);
      chk("single rob",   {27'd0, bus.cdb_rob_idx_o}, 32'd3);
      chk("single prd",   {27'd0, bus.cdb_prd_o}, 32'd17);
      chk("single value", bus.cdb_value_o, 32'hDEAD_BEEF);
      step();
      chk("single t2 valid", {31'd0, bus.cdb_valid_o}, 32'd0);
      chk("single rr",       {30'd0, bus.dbg_rr_ptr_o}, 32'd1);

      //           rst   flush stall push    ra     rl     rm     ev    src   rob    rdy     rr    zero
      // Fairness: LSU alone, then all three at once starting from rr=2.
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b010, 5'd0,  5'd1,  5'd0,  1'b0, 2'd0, 5'd0,  3'b111, 2'd1, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 5'd0,  5'd0,  5'd0,  1'b1, 2'd1, 5'd1,  3'b111, 2'd2, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b111, 5'd4,  5'd5,  5'd6,  1'b0, 2'd0, 5'd0,  3'b111, 2'd2, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 5'd0,  5'd0,  5'd0,  1'b1, 2'd2, 5'd6,  3'b111, 2'd0, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 5'd0,  5'd0,  5'd0,  1'b1, 2'd0, 5'd4,  3'b111, 2'd1, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 5'd0,  5'd0,  5'd0,  1'b1, 2'd1, 5'd5,  3'b111, 2'd2, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 5'd0,  5'd0,  5'd0,  1'b0, 2'd0, 5'd0,  3'b111, 2'd2, 1'b0));
      // Stall with LSU pushing every cycle: MUL 7 held, LSU fills after 8,9; 10 waits.
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b100, 5'd0,  5'd0,  5'd7,  1'b0, 2'd0, 5'd0,  3'b111, 2'd2, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b010, 5'd0,  5'd8,  5'd0,  1'b1, 2'd2, 5'd7,  3'b111, 2'd0, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b1, 3'b010, 5'd0,  5'd9,  5'd0,  1'b1, 2'd2, 5'd7,  3'b101, 2'd0, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b1, 3'b010, 5'd0,  5'd10, 5'd0,  1'b1, 2'd2, 5'd7,  3'b101, 2'd0, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b1, 3'b010, 5'd0,  5'd10, 5'd0,  1'b1, 2'd2, 5'd7,  3'b101, 2'd0, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b1, 3'b010, 5'd0,  5'd10, 5'd0,  1'b1, 2'd2, 5'd7,  3'b101, 2'd0, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b010, 5'd0,  5'd10, 5'd0,  1'b1, 2'd1, 5'd8,  3'b111, 2'd2, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b010, 5'd0,  5'd10, 5'd0,  1'b1, 2'd1, 5'd9,  3'b111, 2'd2, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 5'd0,  5'd0,  5'd0,  1'b1, 2'd1, 5'd10, 3'b111, 2'd2, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 5'd0,  5'd0,  5'd0,  1'b0, 2'd0, 5'd0,  3'b111, 2'd2, 1'b0));
      // Flush with queues filled and a simultaneous MUL push (rob 20 must never appear).
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b111, 5'd13, 5'd14, 5'd15, 1'b0, 2'd0, 5'd0,  3'b111, 2'd2, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b1, 3'b111, 5'd16, 5'd17, 5'd18, 1'b1, 2'd2, 5'd15, 3'b100, 2'd0, 1'b0));
      vt.push_back(mk(1'b0, 1'b1, 1'b1, 3'b100, 5'd0,  5'd0,  5'd20, 1'b0, 2'd0, 5'd0,  3'b111, 2'd0, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 5'd0,  5'd0,  5'd0,  1'b0, 2'd0, 5'd0,  3'b111, 2'd0, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 5'd0,  5'd0,  5'd0,  1'b0, 2'd0, 5'd0,  3'b111, 2'd0, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 5'd0,  5'd0,  5'd0,  1'b0, 2'd0, 5'd0,  3'b111, 2'd0, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b100, 5'd0,  5'd0,  5'd21, 1'b0, 2'd0, 5'd0,  3'b111, 2'd0, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 5'd0,  5'd0,  5'd0,  1'b1, 2'd2, 5'd21, 3'b111, 2'd0, 1'b0));
      // Reset mid-operation with full queues and a stalled output.
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b111, 5'd22, 5'd23, 5'd24, 1'b0, 2'd0, 5'd0,  3'b111, 2'd0, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b1, 3'b111, 5'd25, 5'd26, 5'd27, 1'b1, 2'd0, 5'd22, 3'b001, 2'd1, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b1, 3'b000, 5'd0,  5'd0,  5'd0,  1'b1, 2'd0, 5'd22, 3'b001, 2'd1, 1'b0));
      vt.push_back(mk(1'b1, 1'b0, 1'b1, 3'b111, 5'd31, 5'd31, 5'd31, 1'b0, 2'd0, 5'd0,  3'b111, 2'd0, 1'b1));
      vt.push_back(mk(1'b1, 1'b0, 1'b1, 3'b111, 5'd31, 5'd31, 5'd31, 1'b0, 2'd0, 5'd0,  3'b111, 2'd0, 1'b1));
      for (int i = 0; i < 5; i++)
         vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 5'd0, 3'b111, 2'd0, 1'b1));
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b111, 5'd28, 5'd29, 5'd30, 1'b0, 2'd0, 5'd0,  3'b111, 2'd0, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 5'd0,  5'd0,  5'd0,  1'b1, 2'd0, 5'd28, 3'b111, 2'd1, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 5'd0,  5'd0,  5'd0,  1'b1, 2'd1, 5'd29, 3'b111, 2'd2, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 5'd0,  5'd0,  5'd0,  1'b1, 2'd2, 5'd30, 3'b111, 2'd0, 1'b0));
      vt.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 5'd0,  5'd0,  5'd0,  1'b0, 2'd0, 5'd0,  3'b111, 2'd0, 1'b0));

      foreach (vt[i]) begin
         v = vt[i];
         drive(v.rst, v.flush, v.stall, v.push, v.ra, v.rl, v.rm);
         step();
         tag = $sformatf("v%0d", i);
         chk({tag, " valid"}, {31'd0, bus.cdb_valid_o}, {31'd0, v.ev});
         chk_ready(tag, v.erdy);
         chk({tag, " rr"}, {30'd0, bus.dbg_rr_ptr_o}, {30'd0, v.err});
         if (v.ezero) chk_zero(tag);
         if (v.ev) begin
            chk({tag, " src"},   {30'd0, bus.cdb_src_o}, {30'd0, v.esrc});
            chk({tag, " rob"},   {27'd0, bus.cdb_rob_idx_o}, {27'd0, v.erob});
            chk({tag, " prd"},   {27'd0, bus.cdb_prd_o}, {27'd0, prd_of(v.erob)});
            chk({tag, " value"}, bus.cdb_value_o, val_of(v.esrc, v.erob));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
